// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD character-draw path: arbiter FSM states,
// field widths, the RGB565 palette and the latched draw-parameter record.
package lcd_pkg;

  localparam int ASCII_W = 8;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 16;
  localparam int IDX_W   = 2;   // wide enough for up to four requesters
  localparam int CNT_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } arb_state_e;

  typedef enum logic [COLOR_W-1:0] {
    RGB_BLACK  = 16'h0000,
    RGB_WHITE  = 16'hFFFF,
    RGB_RED    = 16'hF800,
    RGB_GREEN  = 16'h07E0,
    RGB_BLUE   = 16'h001F,
    RGB_YELLOW = 16'hFFE0
  } rgb565_e;

  typedef struct packed {
    logic [ASCII_W-1:0] ascii;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               size;
    logic [COLOR_W-1:0] bg;
    logic [COLOR_W-1:0] fg;
  } draw_t;

  function automatic draw_t draw_reset();
    draw_t d;
    d.ascii = '0;
    d.x     = '0;
    d.y     = '0;
    d.size  = 1'b0;
    d.bg    = RGB_BLACK;
    d.fg    = RGB_BLACK;
    return d;
  endfunction

endpackage

// File: rtl/lcd_char_arbiter_rr_pick.sv
// Round-robin pick: the first asserted request found at last_grant+1,
// last_grant+2, ... wrapping modulo NREQ.
module rr_pick
  import lcd_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: every output is given a default before the search so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    // NOTE: combinational logic uses blocking '='; the search relies on valid updating immediately.
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] && (i == (int'(last_grant) + k) % NREQ)) begin
          valid = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Arbitrates several character-draw requesters onto one LCD character engine:
// round-robin grant, latched draw parameters, start pulse, completion/timeout ack.
module lcd_char_arbiter
  import lcd_pkg::*;
#(
  parameter int               NREQ    = 3,
  parameter logic [CNT_W-1:0] TIMEOUT = 20'd1_000_000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    init_done,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req,
  input  logic [ASCII_W*NREQ-1:0] ascii_in,
  input  logic [COORD_W*NREQ-1:0] x_in,
  input  logic [COORD_W*NREQ-1:0] y_in,
  input  logic [NREQ-1:0]         size_in,
  input  logic [COLOR_W*NREQ-1:0] bg_in,
  input  logic [COLOR_W*NREQ-1:0] fg_in,
  input  logic                    show_char_done,
  output logic [NREQ-1:0]         ack,
  output logic                    show_char_flag,
  output logic [ASCII_W-1:0]      ascii_num,
  output logic [COORD_W-1:0]      start_x,
  output logic [COORD_W-1:0]      start_y,
  output logic                    en_size,
  output logic [COLOR_W-1:0]      background_color,
  output logic [COLOR_W-1:0]      front_color,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT - CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;
  draw_t            draw_q,  draw_d;
  logic             flag_q,  flag_d;
  logic [NREQ-1:0]  ack_q,   ack_d;
  logic             busy_q,  busy_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  draw_t            sel_fields;
  logic [NREQ-1:0]  grant_oh;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Mux out the granted requester's packed fields.
  always_comb begin
    sel_fields = draw_q;
    grant_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        grant_oh[i]      = 1'b1;
        sel_fields.ascii = ascii_in[i*ASCII_W +: ASCII_W];
        sel_fields.x     = x_in[i*COORD_W +: COORD_W];
        sel_fields.y     = y_in[i*COORD_W +: COORD_W];
        sel_fields.size  = size_in[i];
        sel_fields.bg    = bg_in[i*COLOR_W +: COLOR_W];
        sel_fields.fg    = fg_in[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    draw_d  = draw_q;
    flag_d  = 1'b0;
    ack_d   = '0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_done && pick_valid) begin
            grant_d = pick_idx;
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          draw_d  = sel_fields;
          flag_d  = 1'b1;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (show_char_done) begin
            ack_d   = grant_oh;
            state_d = ST_ACK;
          end else if (cnt_q >= TMO_LAST) begin
            err_d   = 1'b1;
            ack_d   = grant_oh;
            state_d = ST_ACK;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACK: begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop updates from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      draw_q  <= draw_reset();
      flag_q  <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      draw_q  <= draw_d;
      flag_q  <= flag_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack              = ack_q;
  assign show_char_flag   = flag_q;
  assign ascii_num        = draw_q.ascii;
  assign start_x          = draw_q.x;
  assign start_y          = draw_q.y;
  assign en_size          = draw_q.size;
  assign background_color = draw_q.bg;
  assign front_color      = draw_q.fg;
  assign busy             = busy_q;
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Bench for lcd_char_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a cycle-stamped transaction model of the arbiter.
module tb_lcd_char_arbiter;
  import lcd_pkg::*;

  localparam int NREQ = 3;
  localparam int TMO  = 16;
  localparam int DW   = ASCII_W + 2*COORD_W + 1 + 2*COLOR_W;
  localparam int AW   = ASCII_W*NREQ;
  localparam int XW   = COORD_W*NREQ;
  localparam int KW   = COLOR_W*NREQ;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic init_done, flush, show_char_done;
  logic [NREQ-1:0] req, size_in, ack;
  logic [AW-1:0] ascii_in;
  logic [XW-1:0] x_in, y_in;
  logic [KW-1:0] bg_in, fg_in;
  logic show_char_flag, en_size, busy, timeout_err;
  logic [ASCII_W-1:0] ascii_num;
  logic [COORD_W-1:0] start_x, start_y;
  logic [COLOR_W-1:0] background_color, front_color;
  logic [DW-1:0] dut_draw;

  assign dut_draw = {ascii_num, start_x, start_y, en_size, background_color, front_color};

  always #5 sys_clk = ~sys_clk;

  lcd_char_arbiter #(.NREQ(NREQ), .TIMEOUT(20'd16)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .init_done        (init_done),
    .flush            (flush),
    .req              (req),
    .ascii_in         (ascii_in),
    .x_in             (x_in),
    .y_in             (y_in),
    .size_in          (size_in),
    .bg_in            (bg_in),
    .fg_in            (fg_in),
    .show_char_done   (show_char_done),
    .ack              (ack),
    .show_char_flag   (show_char_flag),
    .ascii_num        (ascii_num),
    .start_x          (start_x),
    .start_y          (start_y),
    .en_size          (en_size),
    .background_color (background_color),
    .front_color      (front_color),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (cycle-stamped transactions) ----------------
  int            cyc = 0;
  bit            m_free;
  int            m_win, m_last, m_latch_at, m_flag_at, m_ack_at;
  bit            m_err;
  logic [DW-1:0] m_draw;

  function automatic int rr_ref(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] fields_of(input int i);
    return {ascii_in[i*ASCII_W +: ASCII_W], x_in[i*COORD_W +: COORD_W], y_in[i*COORD_W +: COORD_W],
            size_in[i], bg_in[i*COLOR_W +: COLOR_W], fg_in[i*COLOR_W +: COLOR_W]};
  endfunction

  task automatic model_reset();
    m_free = 1'b1; m_win = 0; m_last = NREQ - 1;
    m_latch_at = -1; m_flag_at = -1; m_ack_at = -1;
    m_err = 1'b0; m_draw = '0;
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      check("rst_ctl", {ack, show_char_flag, busy, timeout_err}, '0);
      check("rst_draw", dut_draw, '0);
      model_reset();
    end else begin
      cyc++;
      check("flag", show_char_flag, cyc == m_flag_at);
      check("ack", ack, (cyc == m_ack_at) ? (1 << m_win) : 0);
      check("busy", busy, !m_free);
      check("draw", dut_draw, m_draw);
      check("err", timeout_err, m_err);
      if (flush) begin
        m_free = 1'b1; m_latch_at = -1; m_flag_at = -1; m_ack_at = -1;
      end else if (m_free) begin
        if (init_done && req != '0) begin
          m_win = rr_ref(m_last, req);
          m_free = 1'b0;
          m_latch_at = cyc + 1;
          m_flag_at  = cyc + 2;
          m_ack_at   = -1;
        end
      end else if (cyc == m_latch_at) begin
        m_draw = fields_of(m_win);
      end else if (cyc == m_ack_at) begin
        m_free = 1'b1;
        m_last = m_win;
      end else if (m_ack_at < 0 && cyc > m_flag_at) begin
        if (show_char_done) m_ack_at = cyc + 1;
        else if (cyc - m_flag_at == TMO) begin
          m_ack_at = cyc + 1;
          m_err = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus: requesters and character engine ----------------
  int tcyc = 0, flag_cnt = 0, flag_cyc = 0, ack_cyc = 0, done_cyc = 0;
  int eng_timer = 0, eng_delay = 5;
  bit eng_rand = 1'b0, auto_release = 1'b1;
  logic [NREQ-1:0] ack_log[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
    tcyc++;
    show_char_done = 1'b0;
    if (show_char_flag) begin
      flag_cnt++;
      flag_cyc = tcyc;
      if (eng_rand) eng_timer = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      else eng_timer = eng_delay;
    end else if (eng_timer > 0) begin
      eng_timer--;
      if (eng_timer == 0) begin
        show_char_done = 1'b1;
        done_cyc = tcyc;
      end
    end
    if (ack != '0) begin
      ack_log.push_back(ack);
      ack_cyc = tcyc;
      if (auto_release) req = req & ~ack;
    end
  endtask

  task automatic set_fields(input int i, input logic [7:0] a, input logic [8:0] x, input logic [8:0] y,
                            input logic s, input logic [15:0] bg, input logic [15:0] fg);
    ascii_in[i*ASCII_W +: ASCII_W] = a;
    x_in[i*COORD_W +: COORD_W] = x;
    y_in[i*COORD_W +: COORD_W] = y;
    size_in[i] = s;
    bg_in[i*COLOR_W +: COLOR_W] = bg;
    fg_in[i*COLOR_W +: COLOR_W] = fg;
  endtask

  task automatic wait_flag(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!show_char_flag && lat < 100);
    check({tag, "_flag_seen"}, show_char_flag, 1'b1);
  endtask

  task automatic wait_ack(input string tag, input int n);
    int k = 0;
    while (ack_log.size() < n && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_ack_seen"}, ack_log.size() >= n, 1'b1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    int lat, n0, f0, fc;
    init_done = 1'b1; flush = 1'b0; show_char_done = 1'b0; req = '0;
    ascii_in = '0; x_in = '0; y_in = '0; size_in = '0; bg_in = '0; fg_in = '0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();

    // Single requester 0: latency, latched fields, done-to-ack latency.
    set_fields(0, 8'h41, 9'd10, 9'd20, 1'b0, RGB_BLACK, RGB_WHITE);
    n0 = ack_log.size();
    req = 3'b001;
    wait_flag("t1", lat);
    check("t1_lat", lat, 2);
    check("t1_ascii", ascii_num, 8'h41);
    check("t1_x", start_x, 9'd10);
    check("t1_y", start_y, 9'd20);
    wait_ack("t1", n0 + 1);
    check("t1_ack", ack_log[n0], 3'b001);
    check("t1_done2ack", ack_cyc - done_cyc, 1);

    // All requesters held: rotation from a fresh reset.
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    auto_release = 1'b0;
    for (int i = 0; i < NREQ; i++) set_fields(i, 8'h30 + 8'(i), 9'(i*8), 9'(i*16), i[0], RGB_BLUE, RGB_RED);
    n0 = ack_log.size();
    req = 3'b111;
    wait_ack("t2", n0 + 4);
    check("t2_ack0", ack_log[n0], 3'b001);
    check("t2_ack1", ack_log[n0+1], 3'b010);
    check("t2_ack2", ack_log[n0+2], 3'b100);
    check("t2_ack3", ack_log[n0+3], 3'b001);
    req = '0;
    auto_release = 1'b1;
    wait_idle();

    // init_done low blocks grants; raising it grants requester 1.
    init_done = 1'b0;
    f0 = flag_cnt;
    n0 = ack_log.size();
    req = 3'b010;
    repeat (6) tick();
    check("t3_blocked", flag_cnt, f0);
    init_done = 1'b1;
    wait_flag("t3", lat);
    check("t3_lat", lat, 2);
    wait_ack("t3", n0 + 1);
    check("t3_ack", ack_log[n0], 3'b010);

    // Flush in WAIT: no ack, then requester 2 is granted again.
    wait_idle();
    eng_delay = 0;
    n0 = ack_log.size();
    set_fields(2, 8'h5A, 9'd300, 9'd200, 1'b1, RGB_GREEN, RGB_YELLOW);
    req = 3'b100;
    wait_flag("t4", lat);
    repeat (3) tick();
    flush = 1'b1;
    eng_delay = 3;
    tick();
    flush = 1'b0;
    check("t4_flush_idle", busy, 1'b0);
    check("t4_no_ack", ack_log.size(), n0);
    wait_flag("t4_regrant", lat);
    check("t4_ascii", ascii_num, 8'h5A);
    wait_ack("t4", n0 + 1);
    check("t4_ack", ack_log[n0], 3'b100);

    // Engine never answers: timeout error and ack at flag+17; error is sticky.
    wait_idle();
    eng_delay = 0;
    n0 = ack_log.size();
    req = 3'b001;
    wait_flag("t5", lat);
    fc = flag_cyc;
    wait_ack("t5", n0 + 1);
    check("t5_tmo_lat", ack_cyc - fc, 17);
    check("t5_err", timeout_err, 1'b1);
    eng_delay = 2;
    req = 3'b010;
    wait_ack("t5b", n0 + 2);
    check("t5_err_sticky", timeout_err, 1'b1);

    // Asynchronous reset in WAIT: outputs clear at once, requester 0 wins first.
    wait_idle();
    eng_delay = 0;
    req = 3'b010;
    wait_flag("t6", lat);
    repeat (2) tick();
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {ack, show_char_flag, busy, timeout_err}, '0);
    check("t6_rst_draw", dut_draw, '0);
    tick();
    eng_timer = 0;
    eng_delay = 4;
    n0 = ack_log.size();
    req = 3'b111;
    sys_rst_n = 1'b1;
    wait_ack("t6", n0 + 1);
    check("t6_first", ack_log[n0], 3'b001);

    // Random traffic: fields churn every cycle, req drops, flushes, init_done toggles, stray dones.
    eng_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      ascii_in = AW'({$urandom, $urandom});
      x_in = XW'({$urandom, $urandom});
      y_in = XW'({$urandom, $urandom});
      size_in = NREQ'($urandom);
      bg_in = KW'({$urandom, $urandom});
      fg_in = KW'({$urandom, $urandom});
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
      end
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) init_done = !init_done;
      if ($urandom_range(0, 24) == 0) show_char_done = 1'b1;
    end
    flush = 1'b0;
    init_done = 1'b1;
    req = '0;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_char_arbiter.md
LCD_CHAR_ARBITER -- requirements
Module: lcd_char_arbiter

Interface
REQ-001 The block SHALL take parameter NREQ, default 3; meaning: number of character-draw requesters (range 2..4).
REQ-002 The block SHALL take parameter TIMEOUT, default 20'd1_000_000; meaning: maximum cycles to wait for draw completion.
REQ-003 sys_clk  input  1  system clock (100 MHz).
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 init_done  input  1  LCD init complete; draws are blocked while low.
REQ-006 flush  input  1  abort and drop all activity (mode change).
REQ-007 req  input  NREQ  per-requester level request; held until its ack.
REQ-008 ascii_in  input  8*NREQ  packed ASCII codes, requester i at [8i+7:8i].
REQ-009 x_in / y_in  input  9*NREQ each  packed start coordinates.
REQ-010 size_in  input  NREQ  font select per requester (0 = 12x6, 1 = 16x8).
REQ-011 bg_in / fg_in  input  16*NREQ each  packed RGB565 colors.
REQ-012 ack  output  NREQ  one-cycle pulse to the granted requester on completion.
REQ-013 show_char_flag  output  1  one-cycle start pulse to the character engine.
REQ-014 ascii_num, start_x, start_y, en_size, background_color, front_color  output  8/9/9/1/16/16  registered draw parameters.
REQ-015 show_char_done  input  1  engine completion pulse.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 timeout_err  output  1  sticky flag set on a draw timeout.

Function
REQ-018 FSM states SHALL be IDLE, LATCH, ISSUE, WAIT, ACK.
REQ-019 IDLE: when init_done=1 and req!=0, SHALL select the winner round-robin starting at index (last_grant+1) mod NREQ, then go to LATCH.
REQ-020 LATCH: SHALL register the winner's fields into the draw outputs and store grant_idx; next state ISSUE.
REQ-021 ISSUE: SHALL drive show_char_flag=1 for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-022 WAIT: on show_char_done go to ACK; if the counter reaches TIMEOUT-1, set timeout_err and go to ACK.
REQ-023 ACK: SHALL pulse ack[grant_idx] for one cycle, set last_grant=grant_idx, go to IDLE.
REQ-024 Latency from req rising (in IDLE, init_done=1) to show_char_flag SHALL be 2 cycles; from show_char_done to ack SHALL be 1 cycle.
REQ-025 Draw outputs SHALL remain stable from LATCH until the next LATCH, independent of input changes.
REQ-026 A requester dropping req after grant SHALL NOT abort the draw; ack is still issued.
REQ-027 show_char_done received in any state other than WAIT SHALL be ignored.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge, issue no ack, and leave last_grant and timeout_err unchanged; flush has priority over all other transitions.
REQ-029 init_done falling in WAIT SHALL NOT abort the draw; it only blocks new grants from IDLE.
REQ-030 With all req bits high, grants SHALL rotate 0,1,2,0,... with no requester starved.
REQ-031 The timeout counter SHALL be 20 bits and saturate; it SHALL NOT wrap.

Reset
REQ-032 Asynchronous assertion of sys_rst_n=0 SHALL force IDLE, ack=0, show_char_flag=0, busy=0, timeout_err=0, every draw output=0, last_grant=NREQ-1 (so index 0 wins first), counter=0.
REQ-033 Reset release SHALL take effect at the first sys_clk edge; no output pulses SHALL occur during that cycle.

Structure
REQ-034 FSM state encodings, the RGB565 color constants, and the field widths (8/9/16) SHALL live in shared package lcd_pkg.
REQ-035 Round-robin selection SHALL be a sub-module named rr_pick (inputs req and last_grant; outputs valid and idx).
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Reset, init_done=1, req=3'b001, ascii_in[7:0]=8'h41, x=9'd10, y=9'd20 -> show_char_flag 2 cycles later with ascii_num=8'h41, start_x=10, start_y=20; done -> ack=3'b001 next cycle.
REQ-038 req=3'b111 held, done returned 5 cycles after each flag -> ack order 001, 010, 100, 001.
REQ-039 init_done=0, req=3'b010 -> no flag; raise init_done -> flag 2 cycles later, grant index 1.
REQ-040 flush pulsed in WAIT for req 2 -> IDLE next cycle, no ack; req 2 still high -> regranted.
REQ-041 TIMEOUT=16, done never returned -> timeout_err=1 and ack pulsed at flag+17 cycles; err stays 1 until reset.
REQ-042 Asynchronous reset mid-WAIT -> all outputs 0 immediately; the first grant after release goes to requester 0.
